// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH accepted-bit counter. Produces a registered one-cycle pulse
// after the edge that accepts the last bit of a word.
module sipo_bit_counter #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // The counter depends only on en, so an X on the serial data cannot reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      cnt  <= last_bit ? '0 : cnt + CNT_W'(1);
      wrap <= last_bit;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo.sv
// Serial-in, parallel-out shift register with word-complete strobe.
// pout is a sliding window of the last WIDTH accepted bits.
module sipo #(
  parameter  int WIDTH     = 4,
  parameter  int LSB_FIRST = 0,
  localparam int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             en,
  output logic [WIDTH-1:0] pout,
  output logic             word_valid,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] shift_next;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign shift_next = {sin, pout[WIDTH-1:1]};
    end else begin : g_msb_first
      assign shift_next = {pout[WIDTH-2:0], sin};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pout <= '0;
    end else if (en) begin
      pout <= shift_next;
    end
  end

  sipo_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .cnt (bit_cnt),
    .wrap(word_valid)
  );

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed vector table, LSB_FIRST=1 sequences,
// and randomized traffic against a queue-based model of accepted bits.
module tb_sipo;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] pout0, pout1;
  logic         wv0, wv1;
  logic [1:0]   cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo #(.WIDTH(W), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .sin(sin), .en(en),
    .pout(pout0), .word_valid(wv0), .bit_cnt(cnt0)
  );

  sipo #(.WIDTH(W), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .sin(sin), .en(en),
    .pout(pout1), .word_valid(wv1), .bit_cnt(cnt1)
  );

  // Model: newest accepted bit at index 0, plus total accepted since reset.
  bit       hist[$];
  int       accepted = 0;
  bit       m_wv = 1'b0;
  bit [W-1:0] m_p0, m_p1;
  int       m_cnt;

  typedef struct {
    bit         r;
    bit         e;
    bit         s;
    bit [W-1:0] p;
    bit         w;
    bit [1:0]   c;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit e, bit s, bit [W-1:0] p, bit w, bit [1:0] c);
    vec_t t;
    t.r = r; t.e = e; t.s = s; t.p = p; t.w = w; t.c = c;
    return t;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit e, bit s);
    if (r) begin
      hist.delete();
      accepted = 0;
      m_wv = 1'b0;
    end else if (e) begin
      hist.push_front(s);
      if (hist.size() > W) void'(hist.pop_back());
      accepted++;
      m_wv = (accepted % W) == 0;
    end else begin
      m_wv = 1'b0;
    end
    m_p0 = '0;
    m_p1 = '0;
    for (int k = 0; k < hist.size(); k++) begin
      m_p0[k]       = hist[k];
      m_p1[W-1-k]   = hist[k];
    end
    m_cnt = accepted % W;
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(bit r, bit e, bit s);
    @(negedge clk);
    rst = r; en = e; sin = s;
    @(posedge clk);
    #1;
    model_step(r, e, s);
    check("m0_pout", int'(pout0), int'(m_p0));
    check("m0_wv",   int'(wv0),   int'(m_wv));
    check("m0_cnt",  int'(cnt0),  m_cnt);
    check("m1_pout", int'(pout1), int'(m_p1));
    check("m1_wv",   int'(wv1),   int'(m_wv));
    check("m1_cnt",  int'(cnt1),  m_cnt);
    $display("t=%0t rst=%0b en=%0b sin=%0b | p0=%b wv0=%0b c0=%0d | p1=%b wv1=%0b c1=%0d",
             $time, r, e, s, pout0, wv0, cnt0, pout1, wv1, cnt1);
  endtask

  initial begin
    // Reset
    vecs.push_back(v(1,1,1, 4'b0000,0,0));
    vecs.push_back(v(1,1,1, 4'b0000,0,0));
    // Alternating stream
    vecs.push_back(v(0,1,0, 4'b0000,0,1));
    vecs.push_back(v(0,1,1, 4'b0001,0,2));
    vecs.push_back(v(0,1,0, 4'b0010,0,3));
    vecs.push_back(v(0,1,1, 4'b0101,1,0));
    vecs.push_back(v(0,1,0, 4'b1010,0,1));
    vecs.push_back(v(0,1,1, 4'b0101,0,2));
    vecs.push_back(v(0,1,0, 4'b1010,0,3));
    // Word framing
    vecs.push_back(v(1,1,0, 4'b0000,0,0));
    vecs.push_back(v(0,1,1, 4'b0001,0,1));
    vecs.push_back(v(0,1,0, 4'b0010,0,2));
    vecs.push_back(v(0,1,1, 4'b0101,0,3));
    vecs.push_back(v(0,1,1, 4'b1011,1,0));
    vecs.push_back(v(0,1,0, 4'b0110,0,1));
    vecs.push_back(v(0,1,0, 4'b1100,0,2));
    vecs.push_back(v(0,1,1, 4'b1001,0,3));
    vecs.push_back(v(0,1,0, 4'b0010,1,0));
    // Enable gating
    vecs.push_back(v(1,1,0, 4'b0000,0,0));
    vecs.push_back(v(0,1,1, 4'b0001,0,1));
    vecs.push_back(v(0,1,1, 4'b0011,0,2));
    vecs.push_back(v(0,0,0, 4'b0011,0,2));
    vecs.push_back(v(0,0,1, 4'b0011,0,2));
    vecs.push_back(v(0,0,0, 4'b0011,0,2));
    vecs.push_back(v(0,0,1, 4'b0011,0,2));
    vecs.push_back(v(0,0,0, 4'b0011,0,2));
    vecs.push_back(v(0,1,1, 4'b0111,0,3));
    vecs.push_back(v(0,1,1, 4'b1111,1,0));
    // Reset mid-word, then a fresh word, then en=0 clears the strobe
    vecs.push_back(v(0,1,1, 4'b1111,0,1));
    vecs.push_back(v(0,1,0, 4'b1110,0,2));
    vecs.push_back(v(0,1,1, 4'b1101,0,3));
    vecs.push_back(v(1,1,1, 4'b0000,0,0));
    vecs.push_back(v(0,1,1, 4'b0001,0,1));
    vecs.push_back(v(0,1,1, 4'b0011,0,2));
    vecs.push_back(v(0,1,0, 4'b0110,0,3));
    vecs.push_back(v(0,1,1, 4'b1101,1,0));
    vecs.push_back(v(0,0,1, 4'b1101,0,0));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].s);
      check($sformatf("vec%0d_pout", i), int'(pout0), int'(vecs[i].p));
      check($sformatf("vec%0d_wv", i),   int'(wv0),   int'(vecs[i].w));
      check($sformatf("vec%0d_cnt", i),  int'(cnt0),  int'(vecs[i].c));
    end

    // LSB_FIRST=1 sequences
    step(1, 1, 0);
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    check("lsb_word1_pout", int'(pout1), 4'b0001);
    check("lsb_word1_wv",   int'(wv1),   1);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
    check("lsb_word2_pout", int'(pout1), 4'b1000);
    check("lsb_word2_wv",   int'(wv1),   1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
